// File: rtl/ramb_asym_dp_clr.sv
`timescale 1ns/1ps
// Asymmetric true dual-port block RAM: port B is RATIO x port A wide over one shared array,
// with an optional output register, a post-reset clear sweep (BUSY) and a registered collision flag.
module ramb_asym_dp_clr #(
    parameter int                  WA             = 2,
    parameter int                  RATIO          = 8,
    parameter int                  DEPTH_A        = 8192,
    parameter string               WRITE_MODE_A   = "WRITE_FIRST",
    parameter string               WRITE_MODE_B   = "WRITE_FIRST",
    parameter logic [WA-1:0]       INIT_A         = '0,
    parameter logic [WA*RATIO-1:0] INIT_B         = '0,
    parameter logic [WA-1:0]       SRVAL_A        = '0,
    parameter logic [WA*RATIO-1:0] SRVAL_B        = '0,
    parameter int                  DO_REG         = 0,
    parameter int                  CLEAR_ON_RESET = 1,
    parameter logic [WA-1:0]       CLEAR_VAL      = '0
) (
    input  logic                                        CLK,
    input  logic                                        RST_N,
    input  logic                                        ENA,
    input  logic                                        WEA,
    input  logic                                        SSRA,
    input  logic [$clog2(DEPTH_A)-1:0]                  ADDRA,
    input  logic [WA-1:0]                               DIA,
    output logic [WA-1:0]                               DOA,
    input  logic                                        ENB,
    input  logic                                        WEB,
    input  logic                                        SSRB,
    input  logic [$clog2(DEPTH_A)-$clog2(RATIO)-1:0]    ADDRB,
    input  logic [WA*RATIO-1:0]                         DIB,
    output logic [WA*RATIO-1:0]                         DOB,
    output logic                                        BUSY,
    output logic                                        COLL
);

    localparam int WB      = WA * RATIO;
    localparam int AWA     = $clog2(DEPTH_A);
    localparam int RB      = $clog2(RATIO);
    localparam int AWB     = AWA - RB;
    localparam int LW      = (RB > 0) ? RB : 1;
    localparam int DEPTH_B = DEPTH_A / RATIO;

    localparam logic [AWA-1:0] LANE_MASK = AWA'(RATIO - 1);

    localparam bit A_WF = (WRITE_MODE_A == "WRITE_FIRST");
    localparam bit A_RF = (WRITE_MODE_A == "READ_FIRST");
    localparam bit B_WF = (WRITE_MODE_B == "WRITE_FIRST");
    localparam bit B_RF = (WRITE_MODE_B == "READ_FIRST");

    typedef enum logic {CLEAR, READY} state_t;

    // Stored as B-wide rows of RATIO A-wide lanes; lane 0 is the lowest A address.
    logic [RATIO-1:0][WA-1:0] mem [DEPTH_B];

    state_t         state;
    logic [AWA-1:0] cnt;

    logic [AWB-1:0] row_a;
    logic [LW-1:0]  lane_a;
    logic [AWB-1:0] row_s;
    logic [LW-1:0]  lane_s;
    logic [WA-1:0]  rd_a;
    logic [WB-1:0]  rd_b;

    logic [WA-1:0]  doa_p0;
    logic [WA-1:0]  doa_p1;
    logic [WB-1:0]  dob_p0;
    logic [WB-1:0]  dob_p1;

    assign row_a  = AWB'(ADDRA >> RB);
    assign lane_a = LW'(ADDRA & LANE_MASK);
    assign row_s  = AWB'(cnt >> RB);
    assign lane_s = LW'(cnt & LANE_MASK);

    assign rd_a = mem[row_a][lane_a];
    assign rd_b = mem[ADDRB];

    // Clear-sweep controller: one A word per cycle, BUSY drops on the last write edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            if (CLEAR_ON_RESET != 0) begin
                state <= CLEAR;
                BUSY  <= 1'b1;
            end else begin
                state <= READY;
                BUSY  <= 1'b0;
            end
            cnt <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    cnt <= cnt + AWA'(1);
                    if (cnt == AWA'(DEPTH_A - 1)) begin
                        state <= READY;
                        BUSY  <= 1'b0;
                    end
                end
                default: begin
                    state <= READY;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

    // Storage; the B write is issued last so it wins on an overlapped A word.
    always_ff @(posedge CLK) begin
        if (BUSY) begin
            mem[row_s][lane_s] <= CLEAR_VAL;
        end else begin
            if (ENA && WEA) begin
                mem[row_a][lane_a] <= DIA;
            end
            if (ENB && WEB) begin
                mem[ADDRB] <= DIB;
            end
        end
    end

    // ---- stage p0: array read / write-mode output select ----
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            doa_p0 <= INIT_A;
        end else if (!BUSY && ENA) begin
            if (SSRA) begin
                doa_p0 <= SRVAL_A;
            end else if (!WEA || A_RF) begin
                doa_p0 <= rd_a;
            end else if (A_WF) begin
                doa_p0 <= DIA;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            dob_p0 <= INIT_B;
        end else if (!BUSY && ENB) begin
            if (SSRB) begin
                dob_p0 <= SRVAL_B;
            end else if (!WEB || B_RF) begin
                dob_p0 <= rd_b;
            end else if (B_WF) begin
                dob_p0 <= DIB;
            end
        end
    end

    // ---- stage p1: optional output register, free-running outside the sweep ----
    if (DO_REG != 0) begin : g_doreg
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                doa_p1 <= INIT_A;
                dob_p1 <= INIT_B;
            end else if (!BUSY) begin
                doa_p1 <= (ENA && SSRA) ? SRVAL_A : doa_p0;
                dob_p1 <= (ENB && SSRB) ? SRVAL_B : dob_p0;
            end
        end
    end else begin : g_nodoreg
        assign doa_p1 = doa_p0;
        assign dob_p1 = dob_p0;
    end

    assign DOA = doa_p1;
    assign DOB = dob_p1;

    // Collision: both ports hit the same B row with at least one write.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            COLL <= 1'b0;
        end else begin
            COLL <= !BUSY && ENA && ENB && (WEA || WEB) && (row_a == ADDRB);
        end
    end

endmodule

// File: tb/tb_ramb_asym_dp_clr.sv
`timescale 1ns/1ps
// Directed scoreboard bench for ramb_asym_dp_clr: one DO_REG=0 and one DO_REG=1 instance
// share stimulus; expected outputs are queued with their due cycle and checked on arrival.
module tb_ramb_asym_dp_clr;

    localparam int          WA      = 2;
    localparam int          RATIO   = 8;
    localparam int          DEPTH_A = 64;
    localparam logic [1:0]  INIT_A  = 2'b00;
    localparam logic [15:0] INIT_B  = 16'h1234;
    localparam logic [1:0]  SRVAL_A = 2'b11;
    localparam logic [15:0] SRVAL_B = 16'hBEEF;
    localparam logic [1:0]  CLRV    = 2'b01;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        ENA, WEA, SSRA, ENB, WEB, SSRB;
    logic [5:0]  ADDRA;
    logic [1:0]  DIA;
    logic [2:0]  ADDRB;
    logic [15:0] DIB;

    logic [1:0]  doa0, doa1;
    logic [15:0] dob0, dob1;
    logic        busy0, busy1, coll0, coll1;

    int          cycle  = 0;
    int          checks = 0;
    int          errors = 0;

    int          due_q[$];
    int          kind_q[$];
    logic [15:0] exp_q[$];
    string       tag_q[$];

    always #5 CLK = ~CLK;

    ramb_asym_dp_clr #(
        .WA(WA), .RATIO(RATIO), .DEPTH_A(DEPTH_A),
        .WRITE_MODE_A("READ_FIRST"), .WRITE_MODE_B("WRITE_FIRST"),
        .INIT_A(INIT_A), .INIT_B(INIT_B), .SRVAL_A(SRVAL_A), .SRVAL_B(SRVAL_B),
        .DO_REG(0), .CLEAR_ON_RESET(1), .CLEAR_VAL(CLRV)
    ) dut0 (
        .CLK(CLK), .RST_N(RST_N),
        .ENA(ENA), .WEA(WEA), .SSRA(SSRA), .ADDRA(ADDRA), .DIA(DIA), .DOA(doa0),
        .ENB(ENB), .WEB(WEB), .SSRB(SSRB), .ADDRB(ADDRB), .DIB(DIB), .DOB(dob0),
        .BUSY(busy0), .COLL(coll0)
    );

    ramb_asym_dp_clr #(
        .WA(WA), .RATIO(RATIO), .DEPTH_A(DEPTH_A),
        .WRITE_MODE_A("READ_FIRST"), .WRITE_MODE_B("WRITE_FIRST"),
        .INIT_A(INIT_A), .INIT_B(INIT_B), .SRVAL_A(SRVAL_A), .SRVAL_B(SRVAL_B),
        .DO_REG(1), .CLEAR_ON_RESET(1), .CLEAR_VAL(CLRV)
    ) dut1 (
        .CLK(CLK), .RST_N(RST_N),
        .ENA(ENA), .WEA(WEA), .SSRA(SSRA), .ADDRA(ADDRA), .DIA(DIA), .DOA(doa1),
        .ENB(ENB), .WEB(WEB), .SSRB(SSRB), .ADDRB(ADDRB), .DIB(DIB), .DOB(dob1),
        .BUSY(busy1), .COLL(coll1)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // kinds: 0 DOA dut0, 1 DOB dut0, 2 DOA dut1, 3 DOB dut1, 4 COLL dut0, 5 COLL dut1
    function automatic logic [15:0] observe(input int k);
        case (k)
            0:       return {14'b0, doa0};
            1:       return dob0;
            2:       return {14'b0, doa1};
            3:       return dob1;
            4:       return {15'b0, coll0};
            default: return {15'b0, coll1};
        endcase
    endfunction

    task automatic push_exp(input int kind, input int lat, input logic [15:0] exp, input string tag);
        due_q.push_back(cycle + lat);
        kind_q.push_back(kind);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
    endtask

    task automatic step();
        int i;
        @(posedge CLK);
        #1;
        cycle++;
        i = 0;
        while (i < due_q.size()) begin
            if (due_q[i] == cycle) begin
                check(tag_q[i], observe(kind_q[i]), exp_q[i]);
                due_q.delete(i);
                kind_q.delete(i);
                exp_q.delete(i);
                tag_q.delete(i);
            end else begin
                i++;
            end
        end
    endtask

    task automatic idle();
        ENA  = 1'b0; WEA = 1'b0; SSRA = 1'b0;
        ENB  = 1'b0; WEB = 1'b0; SSRB = 1'b0;
    endtask

    task automatic sweep(input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while (busy0 && n < 200);
        check(tag, 16'(n), 16'd64);
        check({tag, "_dut1"}, {15'b0, busy1}, 16'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        ADDRA = '0; DIA = '0; ADDRB = '0; DIB = '0;
        RST_N = 1'b1;
        #2 RST_N = 1'b0;
        #1;
        check("rst_doa",  {14'b0, doa0}, {14'b0, INIT_A});
        check("rst_dob",  dob0, INIT_B);
        check("rst_doa1", {14'b0, doa1}, {14'b0, INIT_A});
        check("rst_busy", {15'b0, busy0}, 16'd1);
        check("rst_coll", {15'b0, coll0}, 16'd0);
        step();
        step();
        check("rst_hold_busy", {15'b0, busy0}, 16'd1);

        // Sweep with colliding, set and write requests applied: all must be ignored
        RST_N = 1'b1;
        ENA = 1'b1; WEA = 1'b1; SSRA = 1'b1; ADDRA = 6'd9; DIA = 2'b11;
        ENB = 1'b1; WEB = 1'b1; SSRB = 1'b1; ADDRB = 3'd1; DIB = 16'hFFFF;
        sweep("busy_len");
        idle();
        check("busy_doa_hold", {14'b0, doa0}, {14'b0, INIT_A});
        check("busy_dob_hold", dob0, INIT_B);
        check("busy_no_coll",  {15'b0, coll0}, 16'd0);

        // 1: cleared contents through port B
        ENB = 1'b1; ADDRB = 3'd0;
        push_exp(1, 1, 16'h5555, "t1_dob_clear");
        step();
        idle();

        // 2: A writes 0,1,2,3,... then B read assembles lanes
        for (int i = 0; i < 8; i++) begin
            ENA = 1'b1; WEA = 1'b1; ADDRA = 6'(i); DIA = 2'(i % 4);
            push_exp(0, 1, {14'b0, CLRV}, "t2_doa_readfirst");
            step();
        end
        idle();
        ENB = 1'b1; ADDRB = 3'd0;
        push_exp(1, 1, 16'hE4E4, "t2_dob");
        push_exp(3, 2, 16'hE4E4, "t2_dob_reg");
        step();
        idle();
        step();

        // 3: WRITE_FIRST on B, then A lane reads
        ENB = 1'b1; WEB = 1'b1; ADDRB = 3'd1; DIB = 16'hABCD;
        push_exp(1, 1, 16'hABCD, "t3_dob_wf");
        step();
        idle();
        ENA = 1'b1; ADDRA = 6'd8;
        push_exp(0, 1, 16'h0001, "t3_a8");
        step();
        ADDRA = 6'd15;
        push_exp(0, 1, 16'h0002, "t3_a15");
        step();
        idle();

        // 4: write/write collision, B wins
        ENA = 1'b1; WEA = 1'b1; ADDRA = 6'd9; DIA = 2'b11;
        ENB = 1'b1; WEB = 1'b1; ADDRB = 3'd1; DIB = 16'h0000;
        push_exp(4, 1, 16'd1, "t4_coll");
        push_exp(5, 1, 16'd1, "t4_coll_dut1");
        push_exp(0, 1, 16'h0003, "t4_doa_old");
        push_exp(1, 1, 16'h0000, "t4_dob_wf");
        push_exp(4, 2, 16'd0, "t4_coll_pulse");
        step();
        idle();
        step();
        ENA = 1'b1; ADDRA = 6'd9;
        ENB = 1'b1; ADDRB = 3'd1;
        push_exp(0, 1, 16'h0000, "t4_a9_bwins");
        push_exp(1, 1, 16'h0000, "t4_b1");
        push_exp(4, 1, 16'd0, "t4_rr_nocoll");
        step();
        idle();
        // read/write collision: reader sees pre-write data
        ENA = 1'b1; ADDRA = 6'd10;
        ENB = 1'b1; WEB = 1'b1; ADDRB = 3'd1; DIB = 16'hFFFF;
        push_exp(0, 1, 16'h0000, "t4_rw_old");
        push_exp(4, 1, 16'd1, "t4_rw_coll");
        step();
        idle();
        ENA = 1'b1; ADDRA = 6'd10;
        push_exp(0, 1, 16'h0003, "t4_a10_new");
        step();
        idle();
        ENA = 1'b1; WEA = 1'b1; ADDRA = 6'd20; DIA = 2'b10;
        ENB = 1'b1; ADDRB = 3'd1;
        push_exp(4, 1, 16'd0, "t4_diff_row");
        push_exp(0, 1, {14'b0, CLRV}, "t4_a20_old");
        step();
        idle();

        // 5: SSR priority with READ_FIRST, and DO_REG latency
        ENA = 1'b1; WEA = 1'b1; SSRA = 1'b1; ADDRA = 6'd0; DIA = 2'b10;
        push_exp(0, 1, {14'b0, SRVAL_A}, "t5_ssr");
        push_exp(2, 1, {14'b0, SRVAL_A}, "t5_ssr_reg");
        step();
        idle();
        ENA = 1'b1; ADDRA = 6'd0;
        push_exp(0, 1, 16'h0002, "t5_rd");
        push_exp(2, 1, {14'b0, SRVAL_A}, "t5_reg_lat1");
        push_exp(2, 2, 16'h0002, "t5_reg_lat2");
        step();
        idle();
        push_exp(0, 1, 16'h0002, "t5_en0_hold");
        step();
        ENB = 1'b1; SSRB = 1'b1; ADDRB = 3'd2;
        push_exp(1, 1, SRVAL_B, "t5_ssrb");
        push_exp(3, 1, SRVAL_B, "t5_ssrb_reg");
        step();
        idle();

        // 6: reset, interrupted sweep, full restart
        RST_N = 1'b0;
        #1;
        check("t6_rst_doa",  {14'b0, doa0}, {14'b0, INIT_A});
        check("t6_rst_dob",  dob0, INIT_B);
        check("t6_rst_dob1", dob1, INIT_B);
        check("t6_rst_busy", {15'b0, busy0}, 16'd1);
        step();
        RST_N = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
        end
        check("t6_mid_busy", {15'b0, busy0}, 16'd1);
        RST_N = 1'b0;
        #1;
        check("t6_mid_rst_doa", {14'b0, doa0}, {14'b0, INIT_A});
        check("t6_mid_rst_dob", dob0, INIT_B);
        step();
        step();
        RST_N = 1'b1;
        sweep("t6_busy_len");
        idle();
        for (int k = 0; k < 8; k++) begin
            ENB = 1'b1; ADDRB = 3'(k);
            push_exp(1, 1, 16'h5555, "t6_clear_b");
            step();
        end
        idle();
        ENA = 1'b1; ADDRA = 6'd9;
        push_exp(0, 1, {14'b0, CLRV}, "t6_clear_a9");
        step();
        idle();
        step();
        step();

        check("sb_drain", 16'(due_q.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
